alu_vector_checker: RTL
=======================

ALU_VECTOR_CHECKER -- requirements
Module: alu_vector_checker

Interface
REQ-001 Parameter LATENCY, default 0: ALU result latency in clock cycles after its operand inputs change (0 = combinational ALU); legal range 0..3.
REQ-002 Parameter CNT_W, default 16: width of the vector index and pass/fail counters.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse that begins a check run.
REQ-006 vec_valid  input  1  upstream vector present.
REQ-007 vec_ready  output  1  checker accepts a vector this cycle.
REQ-008 vec_a, vec_b  input  8 each  operands.
REQ-009 vec_sel  input  4  ALU operation select.
REQ-010 vec_cin  input  1  carry in.
REQ-011 vec_exp  input  8  expected result.
REQ-012 vec_exp_cout  input  1  expected carry out.
REQ-013 vec_chk_cout  input  1  1 = compare carry out; 0 = carry is don't-care (logical ops).
REQ-014 vec_last  input  1  final vector of the run.
REQ-015 A, B  output  8 each; sel  output  4; carryIn  output  1: registered drive to the ALU.
REQ-016 results  input  8; carryOut  input  1: ALU outputs.
REQ-017 busy, done  output  1 each: run in progress / run complete.
REQ-018 pass_count, fail_count  output  CNT_W each.
REQ-019 first_fail_idx  output  CNT_W; first_fail_sel  output  4; first_fail_got  output  9 {cout,result}; first_fail_exp  output  9.

Function
REQ-020 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN on accepting a vector with vec_last=1; DRAIN->DONE when the compare pipeline is empty; DONE->RUN on start.
REQ-021 start in RUN or DRAIN is ignored; start entering RUN clears counters, index and first-fail registers in the same edge.
REQ-022 vec_ready = 1 only in RUN; accept = vec_valid && vec_ready.
REQ-023 Vector accepted at edge N: A/B/sel/carryIn show it after edge N and hold until the next accept.
REQ-024 Results for that vector sampled at edge N+1+LATENCY; counters and first-fail reflect it after that edge.
REQ-025 Expected values, chk flag and index travel in a LATENCY+1 deep shift pipeline with a valid bit per stage; bubbles (no accept) insert invalid stages and produce no compare.
REQ-026 Pass: results==exp and (chk_cout==0 or carryOut==exp_cout); otherwise fail.
REQ-027 Index starts at 0 per run, increments per accepted vector, wraps modulo 2^CNT_W.
REQ-028 pass_count and fail_count saturate at all-ones, never wrap.
REQ-029 First-fail registers load only on the first fail of a run; later fails do not alter them; they read 0 if no fail.
REQ-030 busy = 1 in RUN and DRAIN; done = 1 in DONE only; both 0 in IDLE.
REQ-031 DRAIN lasts exactly until the last vector's compare edge; done asserts the cycle after it.

Reset
REQ-032 reset has priority over all inputs, including start, and returns the FSM to IDLE regardless of state, including mid-run and mid-drain.
REQ-033 After reset: vec_ready, busy, done = 0; A, B, sel, carryIn = 0; all counters, index, first-fail outputs = 0; every pipeline valid bit = 0 (in-flight compares discarded).

Structure
REQ-034 Shared package alu_pkg holds the 4-bit sel opcode constants, the FSM state enumeration and the 9-bit {cout,result} record width.
REQ-035 One sub-module, alu_chk_pipe: parameterised LATENCY+1 stage shift register of {valid, idx, exp, exp_cout, chk_cout, sel}.

Verification
REQ-036 LATENCY=0, start, 3 vectors ADD 0x0F+0x01 cin0 exp 0x10/0, ALU correct, last on third -> pass_count 3, fail_count 0, done the cycle after the third compare edge.
REQ-037 ALU forced results=0x00 on vector index 2 of 5 (exp 0x7F) -> fail_count 1, first_fail_idx 2, first_fail_got 0x000, first_fail_exp 0x07F; later second fail leaves these unchanged.
REQ-038 AND vector exp 0x0C, chk_cout=0, carryOut=1 -> pass; same with chk_cout=1, exp_cout=0 -> fail.
REQ-039 LATENCY=2, vec_valid toggling every other cycle -> each compare exactly 3 edges after its accept, no compares on bubbles, counts match vector count.
REQ-040 reset asserted in DRAIN with 2 vectors in flight -> next cycle IDLE, all outputs 0, no counter change; start during RUN ignored (counts not cleared).
REQ-041 CNT_W=4, 17 passing vectors -> pass_count saturates at 15, first_fail_idx 0, index wraps to 1 at the end.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ==========================================================================
// alu_pkg : opcodes, checker FSM states and result record shared by the checker
// Rev 1.0
// ==========================================================================
package alu_pkg;

  localparam logic [3:0] c_op_add = 4'h0;
  localparam logic [3:0] c_op_sub = 4'h1;
  localparam logic [3:0] c_op_and = 4'h2;
  localparam logic [3:0] c_op_or  = 4'h3;
  localparam logic [3:0] c_op_xor = 4'h4;

  // Result record is {carry out, 8-bit result}
  localparam int c_res_w = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_e;

  typedef struct packed {
    logic [3:0] sel;
    logic       chk_cout;
    logic       exp_cout;
    logic [7:0] exp;
  } chk_payload_t;

  function automatic logic vec_pass(input logic [c_res_w-1:0] got,
                                    input logic [c_res_w-1:0] exp,
                                    input logic               chk_cout);
    return (got[7:0] == exp[7:0]) && (!chk_cout || (got[8] == exp[8]));
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_chk_pipe.sv
`default_nettype none
// ==========================================================================
// alu_chk_pipe : LATENCY+1 deep shift register carrying expectations to the compare
// Rev 1.0
// ==========================================================================
module alu_chk_pipe
  import alu_pkg::*;
#(
  parameter int LATENCY = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [CNT_W-1:0] i_idx,
  input  chk_payload_t     i_pay,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_idx,
  output chk_payload_t     o_pay,
  output logic             o_busy_next
);

  localparam int c_depth = LATENCY + 1;

  logic [c_depth-1:0] r_valid;
  logic [CNT_W-1:0]   r_idx [c_depth];
  chk_payload_t       r_pay [c_depth];
  logic [c_depth-1:0] w_body;

  always_ff @(posedge clk) begin
    for (int i = c_depth - 1; i > 0; i--) begin
      r_idx[i] <= r_idx[i-1];
      r_pay[i] <= r_pay[i-1];
    end
    r_idx[0] <= i_idx;
    r_pay[0] <= i_pay;
    if (reset) begin
      r_valid <= '0;
    end else begin
      for (int i = c_depth - 1; i > 0; i--) begin
        r_valid[i] <= r_valid[i-1];
      end
      r_valid[0] <= i_push;
    end
  end

  // Anything still in flight once the tail entry has been compared this edge
  always_comb begin
    w_body          = r_valid;
    w_body[LATENCY] = 1'b0;
    o_busy_next     = (|w_body) | i_push;
  end

  assign o_valid = r_valid[LATENCY];
  assign o_idx   = r_idx[LATENCY];
  assign o_pay   = r_pay[LATENCY];

endmodule
`default_nettype wire

// File: rtl/alu_vector_checker.sv
`default_nettype none
// ==========================================================================
// alu_vector_checker : drives vectors into an external ALU and scores its results
// Rev 1.0
// ==========================================================================
module alu_vector_checker
  import alu_pkg::*;
#(
  parameter int LATENCY = 0,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               vec_valid,
  output logic               vec_ready,
  input  logic [7:0]         vec_a,
  input  logic [7:0]         vec_b,
  input  logic [3:0]         vec_sel,
  input  logic               vec_cin,
  input  logic [7:0]         vec_exp,
  input  logic               vec_exp_cout,
  input  logic               vec_chk_cout,
  input  logic               vec_last,
  output logic [7:0]         A,
  output logic [7:0]         B,
  output logic [3:0]         sel,
  output logic               carryIn,
  input  logic [7:0]         results,
  input  logic               carryOut,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   pass_count,
  output logic [CNT_W-1:0]   fail_count,
  output logic [CNT_W-1:0]   first_fail_idx,
  output logic [3:0]         first_fail_sel,
  output logic [c_res_w-1:0] first_fail_got,
  output logic [c_res_w-1:0] first_fail_exp
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  chk_state_e         r_state;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;
  logic [7:0]         r_a;
  logic [7:0]         r_b;
  logic [3:0]         r_sel;
  logic               r_cin;
  logic [CNT_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_pass;
  logic [CNT_W-1:0]   r_fail;
  logic               r_have_fail;
  logic [CNT_W-1:0]   r_ff_idx;
  logic [3:0]         r_ff_sel;
  logic [c_res_w-1:0] r_ff_got;
  logic [c_res_w-1:0] r_ff_exp;

  logic               w_accept;
  logic               w_start_ok;
  chk_payload_t       w_pay_in;
  logic               w_tail_valid;
  logic [CNT_W-1:0]   w_tail_idx;
  chk_payload_t       w_tail_pay;
  logic               w_pipe_busy_next;
  logic [c_res_w-1:0] w_got;
  logic [c_res_w-1:0] w_exp;
  logic               w_pass;

  assign w_accept   = vec_valid && r_ready;
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_comb begin
    w_pay_in          = '0;
    w_pay_in.sel      = vec_sel;
    w_pay_in.chk_cout = vec_chk_cout;
    w_pay_in.exp_cout = vec_exp_cout;
    w_pay_in.exp      = vec_exp;
  end

  alu_chk_pipe #(
    .LATENCY (LATENCY),
    .CNT_W   (CNT_W)
  ) u_pipe (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_accept),
    .i_idx       (r_idx),
    .i_pay       (w_pay_in),
    .o_valid     (w_tail_valid),
    .o_idx       (w_tail_idx),
    .o_pay       (w_tail_pay),
    .o_busy_next (w_pipe_busy_next)
  );

  assign w_got  = {carryOut, results};
  assign w_exp  = {w_tail_pay.exp_cout, w_tail_pay.exp};
  assign w_pass = vec_pass(w_got, w_exp, w_tail_pay.chk_cout);

  // Handshake and status flags are registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_accept && vec_last) begin
            r_state <= ST_DRAIN;
            r_ready <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!w_pipe_busy_next) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sel <= '0;
      r_cin <= 1'b0;
    end else if (w_accept) begin
      r_a   <= vec_a;
      r_b   <= vec_b;
      r_sel <= vec_sel;
      r_cin <= vec_cin;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_start_ok) begin
      r_idx <= '0;
    end else if (w_accept) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // Counters saturate; only the first failure of a run is captured
  always_ff @(posedge clk) begin
    if (reset || w_start_ok) begin
      r_pass      <= '0;
      r_fail      <= '0;
      r_have_fail <= 1'b0;
      r_ff_idx    <= '0;
      r_ff_sel    <= '0;
      r_ff_got    <= '0;
      r_ff_exp    <= '0;
    end else if (w_tail_valid) begin
      if (w_pass) begin
        if (r_pass != c_cnt_max) r_pass <= r_pass + 1'b1;
      end else begin
        if (r_fail != c_cnt_max) r_fail <= r_fail + 1'b1;
        if (!r_have_fail) begin
          r_have_fail <= 1'b1;
          r_ff_idx    <= w_tail_idx;
          r_ff_sel    <= w_tail_pay.sel;
          r_ff_got    <= w_got;
          r_ff_exp    <= w_exp;
        end
      end
    end
  end

  assign vec_ready      = r_ready;
  assign busy           = r_busy;
  assign done           = r_done;
  assign A              = r_a;
  assign B              = r_b;
  assign sel            = r_sel;
  assign carryIn        = r_cin;
  assign pass_count     = r_pass;
  assign fail_count     = r_fail;
  assign first_fail_idx = r_ff_idx;
  assign first_fail_sel = r_ff_sel;
  assign first_fail_got = r_ff_got;
  assign first_fail_exp = r_ff_exp;

endmodule
`default_nettype wire
